// File: rtl/bob_pkg.sv
// Shared constants and entry layout for the branch order buffer.
// Every bob_retire file imports this package.
package bob_pkg;

    localparam int DEPTH    = 16;
    localparam int LOGDEPTH = 4;
    localparam int BHRW     = 12;
    localparam int LHW      = 10;
    localparam int PTRW     = LOGDEPTH + 1;

    typedef struct packed {
        logic [63:0]     pc;
        logic [BHRW-1:0] bhr;
        logic [LHW-1:0]  lochist;
        logic            pred;
        logic            dir;
        logic            resolved;
        logic            valid;
    } bob_entry_t;

    // The part of an entry that is written once at allocation and kept in the RAM
    typedef struct packed {
        logic [63:0]     pc;
        logic [BHRW-1:0] bhr;
        logic [LHW-1:0]  lochist;
        logic            pred;
    } bob_payload_t;

    function automatic bob_entry_t makeEntry(bob_payload_t payload, logic dir, logic resolved, logic valid);
        bob_entry_t e;
        e.pc       = payload.pc;
        e.bhr      = payload.bhr;
        e.lochist  = payload.lochist;
        e.pred     = payload.pred;
        e.dir      = dir;
        e.resolved = resolved;
        e.valid    = valid;
        return e;
    endfunction

endpackage

// File: rtl/bob_retire_if.sv
// Fetch/execute/commit-facing signal bundle of the branch order buffer.
// The slave modport is the buffer; the master modport is whoever drives it.
interface bob_retire_if;
    import bob_pkg::*;

    logic                flush_i;
    logic                alloc_valid_i;
    logic [63:0]         alloc_pc_i;
    logic [BHRW-1:0]     alloc_bhr_i;
    logic [LHW-1:0]      alloc_lochist_i;
    logic                alloc_pred_i;
    logic                alloc_ready_o;
    logic [LOGDEPTH-1:0] alloc_tag_o;
    logic                resolve_valid_i;
    logic [LOGDEPTH-1:0] resolve_tag_i;
    logic                resolve_brdir_i;
    logic                retire_en_i;
    logic                bob_valid_r_o;
    logic [63:0]         bob_pc_r_o;
    logic [BHRW-1:0]     bob_bhr_r_o;
    logic [LHW-1:0]      bob_lochist_r_o;
    logic                bpd_rt_ud_o;
    logic                bpd_rt_brdir_o;
    logic                bob_flush_o;
    logic [PTRW-1:0]     bob_count_o;

    modport master (
        output flush_i, alloc_valid_i, alloc_pc_i, alloc_bhr_i, alloc_lochist_i, alloc_pred_i,
        output resolve_valid_i, resolve_tag_i, resolve_brdir_i, retire_en_i,
        input  alloc_ready_o, alloc_tag_o, bob_valid_r_o, bob_pc_r_o, bob_bhr_r_o,
        input  bob_lochist_r_o, bpd_rt_ud_o, bpd_rt_brdir_o, bob_flush_o, bob_count_o
    );

    modport slave (
        input  flush_i, alloc_valid_i, alloc_pc_i, alloc_bhr_i, alloc_lochist_i, alloc_pred_i,
        input  resolve_valid_i, resolve_tag_i, resolve_brdir_i, retire_en_i,
        output alloc_ready_o, alloc_tag_o, bob_valid_r_o, bob_pc_r_o, bob_bhr_r_o,
        output bob_lochist_r_o, bpd_rt_ud_o, bpd_rt_brdir_o, bob_flush_o, bob_count_o
    );

endinterface

// File: rtl/bob_ram.sv
// Payload storage for the branch order buffer: one write port at the tail,
// one combinational read port at the head. Contents need no reset.
module bob_ram
    import bob_pkg::*;
(
    input  logic                clock,
    input  logic                i_we,
    input  logic [LOGDEPTH-1:0] i_waddr,
    input  bob_payload_t        i_wdata,
    input  logic [LOGDEPTH-1:0] i_raddr,
    output bob_payload_t        o_rdata
);

    bob_payload_t r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bob_retire.sv
// Branch order buffer: allocates at fetch, records resolution from execute,
// retires in order and drives the predictor update/repair interface.
module bob_retire
    import bob_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    bob_retire_if.slave  bus
);

    logic [PTRW-1:0]     r_head;
    logic [PTRW-1:0]     r_tail;
    logic [DEPTH-1:0]    r_valid;
    logic [DEPTH-1:0]    r_resolved;
    logic [DEPTH-1:0]    r_dir;

    logic                r_bobValid;
    logic [63:0]         r_bobPc;
    logic [BHRW-1:0]     r_bobBhr;
    logic [LHW-1:0]      r_bobLochist;
    logic                r_bpdUd;
    logic                r_bpdBrdir;
    logic                r_bobFlush;

    logic [LOGDEPTH-1:0] w_headIdx;
    logic [LOGDEPTH-1:0] w_tailIdx;
    logic                w_empty;
    logic                w_full;
    logic                w_retireFire;
    logic                w_retireMisp;
    logic                w_allocReady;
    logic                w_allocFire;
    logic                w_resolveFire;
    bob_payload_t        w_allocData;
    bob_payload_t        w_headData;
    bob_entry_t          w_headEntry;

    assign w_headIdx = r_head[LOGDEPTH-1:0];
    assign w_tailIdx = r_tail[LOGDEPTH-1:0];
    assign w_empty   = (r_head == r_tail);
    assign w_full    = (r_head[PTRW-1] != r_tail[PTRW-1]) && (w_headIdx == w_tailIdx);

    assign w_allocData.pc      = bus.alloc_pc_i;
    assign w_allocData.bhr     = bus.alloc_bhr_i;
    assign w_allocData.lochist = bus.alloc_lochist_i;
    assign w_allocData.pred    = bus.alloc_pred_i;

    bob_ram u_ram (
        .clock   (clock),
        .i_we    (w_allocFire),
        .i_waddr (w_tailIdx),
        .i_wdata (w_allocData),
        .i_raddr (w_headIdx),
        .o_rdata (w_headData)
    );

    assign w_headEntry = makeEntry(w_headData, r_dir[w_headIdx], r_resolved[w_headIdx], r_valid[w_headIdx]);

    assign w_retireFire  = bus.retire_en_i && !w_empty && w_headEntry.valid && w_headEntry.resolved && !bus.flush_i;
    assign w_retireMisp  = w_retireFire && (w_headEntry.dir != w_headEntry.pred);
    assign w_allocReady  = !w_full && !w_retireMisp && !bus.flush_i;
    assign w_allocFire   = bus.alloc_valid_i && w_allocReady;
    assign w_resolveFire = bus.resolve_valid_i && r_valid[bus.resolve_tag_i] && !bus.flush_i && !w_retireMisp;

    // Flush wins over everything; a mispredicting retire squashes all younger entries.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_valid      <= '0;
            r_resolved   <= '0;
            r_dir        <= '0;
            r_bobValid   <= 1'b0;
            r_bobPc      <= '0;
            r_bobBhr     <= '0;
            r_bobLochist <= '0;
            r_bpdUd      <= 1'b0;
            r_bpdBrdir   <= 1'b0;
            r_bobFlush   <= 1'b0;
        end else begin
            r_bobValid <= 1'b0;
            r_bpdUd    <= 1'b0;
            r_bobFlush <= 1'b0;
            if (bus.flush_i) begin
                r_bobFlush <= 1'b1;
                r_bpdBrdir <= 1'b0;
                r_bobValid <= !w_empty;
                if (!w_empty) begin
                    r_bobPc      <= w_headEntry.pc;
                    r_bobBhr     <= w_headEntry.bhr;
                    r_bobLochist <= w_headEntry.lochist;
                end
                r_valid    <= '0;
                r_resolved <= '0;
                r_tail     <= r_head;
            end else begin
                if (w_resolveFire) begin
                    r_resolved[bus.resolve_tag_i] <= 1'b1;
                    r_dir[bus.resolve_tag_i]      <= bus.resolve_brdir_i;
                end
                if (w_retireFire) begin
                    r_bobValid          <= 1'b1;
                    r_bpdUd             <= 1'b1;
                    r_bpdBrdir          <= w_headEntry.dir;
                    r_bobPc             <= w_headEntry.pc;
                    r_bobBhr            <= w_headEntry.bhr;
                    r_bobLochist        <= w_headEntry.lochist;
                    r_bobFlush          <= w_retireMisp;
                    r_valid[w_headIdx]  <= 1'b0;
                    r_head              <= r_head + PTRW'(1);
                    if (w_retireMisp) begin
                        r_valid    <= '0;
                        r_resolved <= '0;
                        r_tail     <= r_head + PTRW'(1);
                    end
                end
                if (w_allocFire) begin
                    r_valid[w_tailIdx]    <= 1'b1;
                    r_resolved[w_tailIdx] <= 1'b0;
                    r_tail                <= r_tail + PTRW'(1);
                end
            end
        end
    end

    assign bus.alloc_ready_o   = w_allocReady;
    assign bus.alloc_tag_o     = w_tailIdx;
    assign bus.bob_count_o     = r_tail - r_head;
    assign bus.bob_valid_r_o   = r_bobValid;
    assign bus.bob_pc_r_o      = r_bobPc;
    assign bus.bob_bhr_r_o     = r_bobBhr;
    assign bus.bob_lochist_r_o = r_bobLochist;
    assign bus.bpd_rt_ud_o     = r_bpdUd;
    assign bus.bpd_rt_brdir_o  = r_bpdBrdir;
    assign bus.bob_flush_o     = r_bobFlush;

endmodule

// File: tb/tb_bob_retire.sv
// Self-checking bench for bob_retire: directed scenarios followed by random
// traffic, all compared against a queue-based model of the buffer.
module tb_bob_retire;
    import bob_pkg::*;

    logic clock = 1'b0;
    logic reset;

    bob_retire_if bus ();

    bob_retire dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0]     pc;
        logic [BHRW-1:0] bhr;
        logic [LHW-1:0]  lh;
        logic            pred;
        logic            dir;
        logic            resolved;
    } mEnt_t;

    mEnt_t           mq[$];
    int              mHead;
    logic            eValid, eUd, eBrdir, eFlush;
    logic [63:0]     ePc;
    logic [BHRW-1:0] eBhr;
    logic [LHW-1:0]  eLh;
    int              checks = 0;
    int              errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mHead  = 0;
        eValid = 1'b0; eUd = 1'b0; eBrdir = 1'b0; eFlush = 1'b0;
        ePc    = '0;   eBhr = '0;  eLh = '0;
    endtask

    // Drives one cycle, checks the combinational outputs before the edge and
    // the registered outputs after it, advancing the model in between.
    task automatic applyStimulus(input logic fl, input logic av, input logic [63:0] pc,
                                 input logic [BHRW-1:0] bhr, input logic [LHW-1:0] lh,
                                 input logic pred, input logic rv, input logic [3:0] rtag,
                                 input logic rdir, input logic ren);
        int    sz;
        logic  fire, misp, ready;
        mEnt_t tmp;
        bus.flush_i         = fl;
        bus.alloc_valid_i   = av;
        bus.alloc_pc_i      = pc;
        bus.alloc_bhr_i     = bhr;
        bus.alloc_lochist_i = lh;
        bus.alloc_pred_i    = pred;
        bus.resolve_valid_i = rv;
        bus.resolve_tag_i   = rtag;
        bus.resolve_brdir_i = rdir;
        bus.retire_en_i     = ren;
        #1;
        sz    = mq.size();
        fire  = !fl && ren && (sz > 0) && mq[0].resolved;
        misp  = fire && (mq[0].dir != mq[0].pred);
        ready = !fl && (sz < DEPTH) && !misp;
        checkOutput("alloc_ready", 64'(bus.alloc_ready_o), 64'(ready));
        checkOutput("alloc_tag", 64'(bus.alloc_tag_o), 64'((mHead + sz) % DEPTH));
        checkOutput("count", 64'(bus.bob_count_o), 64'(sz));

        if (fl) begin
            eFlush = 1'b1; eUd = 1'b0; eBrdir = 1'b0;
            eValid = (sz > 0);
            if (sz > 0) begin
                ePc = mq[0].pc; eBhr = mq[0].bhr; eLh = mq[0].lh;
            end
            mq.delete();
        end else begin
            eValid = fire; eUd = fire; eFlush = misp;
            if (fire) begin
                eBrdir = mq[0].dir; ePc = mq[0].pc; eBhr = mq[0].bhr; eLh = mq[0].lh;
            end
            if (rv && !misp) begin
                for (int i = 0; i < sz; i++) begin
                    if (((mHead + i) % DEPTH) == int'(rtag)) begin
                        tmp = mq[i]; tmp.resolved = 1'b1; tmp.dir = rdir; mq[i] = tmp;
                    end
                end
            end
            if (fire) begin
                void'(mq.pop_front());
                mHead = (mHead + 1) % DEPTH;
                if (misp) mq.delete();
            end
            if (av && ready) begin
                tmp.pc = pc; tmp.bhr = bhr; tmp.lh = lh; tmp.pred = pred;
                tmp.dir = 1'b0; tmp.resolved = 1'b0;
                mq.push_back(tmp);
            end
        end

        @(posedge clock);
        #1;
        checkOutput("bob_valid", 64'(bus.bob_valid_r_o), 64'(eValid));
        checkOutput("bpd_ud", 64'(bus.bpd_rt_ud_o), 64'(eUd));
        checkOutput("bob_flush", 64'(bus.bob_flush_o), 64'(eFlush));
        if (eUd || fl) checkOutput("bpd_brdir", 64'(bus.bpd_rt_brdir_o), 64'(eBrdir));
        if (eValid) begin
            checkOutput("bob_pc", bus.bob_pc_r_o, ePc);
            checkOutput("bob_bhr", 64'(bus.bob_bhr_r_o), 64'(eBhr));
            checkOutput("bob_lochist", 64'(bus.bob_lochist_r_o), 64'(eLh));
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 64'h0, '0, '0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic allocCycle(input logic [63:0] pc, input logic [BHRW-1:0] bhr, input logic pred);
        applyStimulus(1'b0, 1'b1, pc, bhr, LHW'(pc[9:0]), pred, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic resolveCycle(input logic [3:0] tag, input logic dir);
        applyStimulus(1'b0, 1'b0, 64'h0, '0, '0, 1'b0, 1'b1, tag, dir, 1'b0);
    endtask

    task automatic retireCycle();
        applyStimulus(1'b0, 1'b0, 64'h0, '0, '0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic flushCycle();
        applyStimulus(1'b1, 1'b0, 64'h0, '0, '0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic            rFl, rAv, rRv, rDir, rRen, rPred;
        logic [3:0]      rTag;
        logic [63:0]     rPc;
        reset = 1'b1;
        bus.flush_i = 1'b0; bus.alloc_valid_i = 1'b0; bus.alloc_pc_i = '0;
        bus.alloc_bhr_i = '0; bus.alloc_lochist_i = '0; bus.alloc_pred_i = 1'b0;
        bus.resolve_valid_i = 1'b0; bus.resolve_tag_i = '0; bus.resolve_brdir_i = 1'b0;
        bus.retire_en_i = 1'b0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        checkOutput("rst_bob_valid", 64'(bus.bob_valid_r_o), 64'h0);
        checkOutput("rst_bpd_ud", 64'(bus.bpd_rt_ud_o), 64'h0);
        checkOutput("rst_bob_flush", 64'(bus.bob_flush_o), 64'h0);
        idleCycle();

        // Correctly predicted branch retires
        allocCycle(64'h1000, 12'hABC, 1'b1);
        resolveCycle(4'd0, 1'b1);
        retireCycle();
        checkOutput("t2_pc", bus.bob_pc_r_o, 64'h1000);
        checkOutput("t2_bhr", 64'(bus.bob_bhr_r_o), 64'hABC);
        checkOutput("t2_ud", 64'(bus.bpd_rt_ud_o), 64'h1);
        idleCycle();

        // Mispredicted head squashes younger entries
        allocCycle(64'h2000, 12'h111, 1'b0);
        allocCycle(64'h2004, 12'h222, 1'b1);
        allocCycle(64'h2008, 12'h333, 1'b1);
        resolveCycle(4'(mHead), 1'b1);
        retireCycle();
        checkOutput("t3_flush", 64'(bus.bob_flush_o), 64'h1);
        checkOutput("t3_brdir", 64'(bus.bpd_rt_brdir_o), 64'h1);
        idleCycle();

        // Fill, overflow attempt, retire, then retire+alloc together across the wrap
        for (int i = 0; i < DEPTH + 1; i++) allocCycle(64'h3000 + 64'(i * 4), BHRW'(i), 1'b1);
        checkOutput("t4_full_count", 64'(bus.bob_count_o), 64'(DEPTH));
        resolveCycle(4'(mHead), 1'b1);
        retireCycle();
        resolveCycle(4'(mHead), 1'b1);
        applyStimulus(1'b0, 1'b1, 64'h4000, 12'h444, 10'h44, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        idleCycle();

        // External flush with and without live entries
        flushCycle();
        allocCycle(64'h5000, 12'h155, 1'b0);
        allocCycle(64'h5004, 12'h2AA, 1'b1);
        flushCycle();
        checkOutput("t5_bhr", 64'(bus.bob_bhr_r_o), 64'h155);
        checkOutput("t5_valid", 64'(bus.bob_valid_r_o), 64'h1);
        flushCycle();
        checkOutput("t5_empty_valid", 64'(bus.bob_valid_r_o), 64'h0);

        // Resolve to an invalid tag, retire of an unresolved head
        resolveCycle(4'd5, 1'b1);
        allocCycle(64'h6000, 12'h666, 1'b0);
        retireCycle();
        allocCycle(64'h6004, 12'h667, 1'b1);
        resolveCycle(4'(mHead), 1'b1);
        retireCycle();

        // Asynchronous reset in the middle of a cycle
        #3;
        reset = 1'b1;
        #1;
        checkOutput("arst_bob_valid", 64'(bus.bob_valid_r_o), 64'h0);
        checkOutput("arst_bpd_ud", 64'(bus.bpd_rt_ud_o), 64'h0);
        checkOutput("arst_bob_flush", 64'(bus.bob_flush_o), 64'h0);
        checkOutput("arst_pc", bus.bob_pc_r_o, 64'h0);
        checkOutput("arst_count", 64'(bus.bob_count_o), 64'h0);
        checkOutput("arst_tag", 64'(bus.alloc_tag_o), 64'h0);
        modelReset();
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rFl   = ($urandom_range(0, 29) == 0);
            rAv   = ($urandom_range(0, 9) < 6);
            rRv   = ($urandom_range(0, 1) == 1);
            rRen  = ($urandom_range(0, 3) != 0);
            rPred = ($urandom_range(0, 4) != 0);
            rDir  = ($urandom_range(0, 4) != 0);
            rPc   = {$urandom, $urandom};
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                rTag = 4'((mHead + int'($urandom_range(0, mq.size() - 1))) % DEPTH);
            else
                rTag = 4'($urandom_range(0, 15));
            applyStimulus(rFl, rAv, rPc, BHRW'($urandom), LHW'($urandom), rPred, rRv, rTag, rDir, rRen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bob_retire.md
Name: bob_retire

Overview:
- Branch order buffer that stores the speculative prediction context for each in-flight conditional branch. Contents per branch: PC, global BHR, local history and predicted direction.
- Allocates entries in program order at fetch, records resolved direction from execute, and retires entries in order at commit.
- At retire it drives the predictor update/repair interface: PHT write indexes, BHR restore, flush.
- Writer-side counterpart of the bpd1 predictor's bob_*/bpd_rt_* inputs.

Parameters:
DEPTH, 16, number of entries (power of 2)
LOGDEPTH, 4, log2(DEPTH)
BHRW, 12, global history width
LHW, 10, local history width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
flush_i  in  1  external pipeline flush (exception/trap)
alloc_valid_i  in  1  fetch allocates a conditional branch
alloc_pc_i  in  64  branch PC
alloc_bhr_i  in  BHRW  global BHR used for prediction
alloc_lochist_i  in  LHW  local history used for prediction
alloc_pred_i  in  1  final predicted direction
alloc_ready_o  out  1  entry available
alloc_tag_o  out  LOGDEPTH  tag of entry being allocated (current tail)
resolve_valid_i  in  1  execute resolves a branch
resolve_tag_i  in  LOGDEPTH  tag being resolved
resolve_brdir_i  in  1  actual direction
retire_en_i  in  1  commit permits head branch to retire
bob_valid_r_o  out  1  bob_* outputs carry valid entry context
bob_pc_r_o  out  64  PC of retired/restoring entry
bob_bhr_r_o  out  BHRW  BHR of that entry
bob_lochist_r_o  out  LHW  local history of that entry
bpd_rt_ud_o  out  1  predictor table update strobe
bpd_rt_brdir_o  out  1  actual direction for update
bob_flush_o  out  1  predictor/front-end flush
bob_count_o  out  LOGDEPTH+1  occupied entries

Behaviour:
- Reset: clears head, tail, all valid/resolved bits, and every output register to 0. alloc_ready_o=1, alloc_tag_o=0.
- Pointers: head and tail are each LOGDEPTH+1 bits.
  - empty = (head==tail).
  - full = MSBs differ and the low bits are equal.
  - bob_count_o = tail-head, modulo 2^(LOGDEPTH+1).
- alloc_ready_o = !full & !retire_mispredict & !flush_i. It is combinational.
- Alloc: when alloc_valid_i & alloc_ready_o, write the entry at tail, set valid=1 and resolved=0, then tail++. alloc_valid_i while not ready is dropped silently.
- Resolve: when resolve_valid_i and the entry at resolve_tag_i is valid, set resolved=1 and dir=resolve_brdir_i.
  - Resolve to an invalid entry is ignored.
  - Re-resolve overwrites dir.
  - Resolve is ignored in any cycle where flush_i or retire_mispredict is active.
- Retire condition: retire_fire = retire_en_i & !empty & head.resolved & !flush_i.
  - The resolved bit is registered, so a branch resolved in cycle N retires no earlier than N+1.
- retire_mispredict = retire_fire & (head.dir != head.pred).
- Retire outputs are registered and valid at N+1 for one cycle only:
  - bob_valid_r_o=1, bpd_rt_ud_o=1.
  - bpd_rt_brdir_o = head.dir.
  - bob_pc_r_o, bob_bhr_r_o, bob_lochist_r_o = head fields.
  - bob_flush_o = retire_mispredict.
  - Head entry is invalidated and head++.
- Mispredict retire: all younger entries are wrong-path. Clear all valid bits and set tail <= head+1, so the buffer becomes empty. Allocation is blocked that cycle.
- flush_i (highest priority):
  - Registered outputs: bob_flush_o=1, bpd_rt_ud_o=0, bpd_rt_brdir_o=0.
  - If non-empty: bob_valid_r_o=1 and bob_* = head (oldest) entry fields, so the predictor restores BHR to before the oldest unretired branch.
  - If empty: bob_valid_r_o=0.
  - All entries are cleared, tail<=head, and any same-cycle retire, resolve or alloc is suppressed.
- Idle cycles: bob_valid_r_o, bpd_rt_ud_o and bob_flush_o are 0. Data outputs hold their last value.
- Wrap-around: tags wrap modulo DEPTH. The pointer MSB disambiguates full from empty.
- Simultaneous alloc and non-mispredict retire are both performed. Count is unchanged.

Decomposition:
- Package bob_pkg holds the parameter defaults, plus:
  - the entry struct typedef {pc, bhr, lochist, pred, dir, resolved, valid};
  - the pointer-width constant.
- One sub-module, bob_ram: a DEPTH x entry register array with one write port (alloc) and a combinational read at head. Valid/resolved/dir bits stay in bob_retire as flops, because they need per-entry clear and resolve writes.

Test Plan:
1. Reset: after reset, alloc_ready_o=1, alloc_tag_o=0, bob_count_o=0, all strobes 0.
2. Alloc pc=0x1000, bhr=0xABC, pred=1; resolve tag 0 dir=1; retire_en_i. Next cycle: bpd_rt_ud_o=1, brdir=1, bob_pc_r_o=0x1000, bob_bhr_r_o=0xABC, bob_flush_o=0. Count goes 1 then 0.
3. Alloc 3 branches (pred 0,1,1); resolve tag 0 with dir=1; retire. Next cycle: bob_flush_o=1, bpd_rt_ud_o=1, brdir=1. Count becomes 0 and the next alloc_tag_o=1.
4. Fill 16 entries: alloc_ready_o=0 and a 17th alloc is dropped. Retire one and alloc one in the same cycle: count stays 16 and tail wraps to tag 0.
5. Alloc 2 entries (head bhr=0x155), then pulse flush_i: next cycle bob_flush_o=1, bob_valid_r_o=1, bob_bhr_r_o=0x155, bpd_rt_ud_o=0, count 0. Repeat with the buffer empty: bob_valid_r_o=0.
6. Resolve tag 5 while entry 5 is invalid: no state change. Assert retire_en_i with head unresolved: no output strobe. Assert reset mid-stream: all outputs 0 immediately (asynchronous).
